// File: rtl/sram_1rw_ctrl.sv
// Valid/ready front-end that sequences CSb/WEb/OEb and the shared data bus of a 1RW SRAM.
// Define SRAM_CTRL_STATS_EN to add the wr_count/rd_count activity counters.
module sram_1rw_ctrl #(
    parameter int DATA_WIDTH = 128,
    parameter int ADDR_WIDTH = 10
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic                  req_we,
    input  logic [ADDR_WIDTH-1:0] req_addr,
    input  logic [DATA_WIDTH-1:0] req_wdata,
    output logic                  rsp_valid,
    output logic [DATA_WIDTH-1:0] rsp_rdata,
    output logic [ADDR_WIDTH-1:0] sram_addr,
    inout  wire  [DATA_WIDTH-1:0] sram_data,
    output logic                  sram_csb,
    output logic                  sram_web,
    output logic                  sram_oeb
`ifdef SRAM_CTRL_STATS_EN
    ,
    output logic [31:0]           wr_count,
    output logic [31:0]           rd_count
`endif
);

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        WRITE     = 2'd1,
        READ      = 2'd2,
        READ_WAIT = 2'd3
    } state_e;

    state_e                  state_q, state_d;
    logic                    accept;
    logic                    csb_q, web_q, oeb_q;
    logic [ADDR_WIDTH-1:0]   addr_q;
    logic [DATA_WIDTH-1:0]   wdata_q;
    logic                    rsp_valid_q;
    logic [DATA_WIDTH-1:0]   rsp_rdata_q;

    // Strobe pattern {csb, web, oeb} presented to the SRAM while in a given state.
    function automatic logic [2:0] strobes_for(input state_e s);
        case (s)
            WRITE:           return 3'b001;
            READ, READ_WAIT: return 3'b010;
            default:         return 3'b111;
        endcase
    endfunction

    assign req_ready = (state_q != READ);
    assign accept    = req_valid && req_ready;

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE, WRITE, READ_WAIT: begin
                if (accept) begin
                    state_d = req_we ? WRITE : READ;
                end else begin
                    state_d = IDLE;
                end
            end
            READ:    state_d = READ_WAIT;
            default: state_d = IDLE;
        endcase
    end

    // Strobes are registered from the next state so they line up with the state they describe.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= IDLE;
            csb_q       <= 1'b1;
            web_q       <= 1'b1;
            oeb_q       <= 1'b1;
            addr_q      <= '0;
            rsp_valid_q <= 1'b0;
            rsp_rdata_q <= '0;
        end else begin
            state_q                <= state_d;
            {csb_q, web_q, oeb_q}  <= strobes_for(state_d);
            rsp_valid_q            <= (state_q == READ_WAIT);
            if (state_q == READ_WAIT) begin
                rsp_rdata_q <= sram_data;
            end
            if (accept) begin
                addr_q  <= req_addr;
                wdata_q <= req_wdata;
            end
        end
    end

    // WEb low makes the SRAM release the bus in the same cycle, so no turnaround is needed.
    assign sram_data = web_q ? {DATA_WIDTH{1'bz}} : wdata_q;

    assign sram_addr = addr_q;
    assign sram_csb  = csb_q;
    assign sram_web  = web_q;
    assign sram_oeb  = oeb_q;
    assign rsp_valid = rsp_valid_q;
    assign rsp_rdata = rsp_rdata_q;

`ifdef SRAM_CTRL_STATS_EN
    logic [31:0] wr_count_q, rd_count_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_count_q <= '0;
            rd_count_q <= '0;
        end else begin
            if (state_q == WRITE) begin
                wr_count_q <= wr_count_q + 32'd1;
            end
            if (rsp_valid_q) begin
                rd_count_q <= rd_count_q + 32'd1;
            end
        end
    end

    assign wr_count = wr_count_q;
    assign rd_count = rd_count_q;
`endif

endmodule

// File: tb/tb_sram_1rw_ctrl.sv
// Bench for sram_1rw_ctrl: behavioural SRAM on the bus, directed scenarios plus a randomized run.
module tb_sram_1rw_ctrl;
    localparam int DW    = 128;
    localparam int AW    = 10;
    localparam int DEPTH = 1 << AW;

    typedef struct packed {
        logic [DW-1:0] data;
        int            due;
    } exp_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          reset;
    logic          req_valid, req_we, req_ready;
    logic [AW-1:0] req_addr;
    logic [DW-1:0] req_wdata;
    logic          rsp_valid;
    logic [DW-1:0] rsp_rdata;
    logic [AW-1:0] sram_addr;
    wire  [DW-1:0] sram_data;
    logic          sram_csb, sram_web, sram_oeb;
`ifdef SRAM_CTRL_STATS_EN
    logic [31:0]   wr_count, rd_count;
`endif

    int n_tests = 0;
    int n_fail  = 0;

    sram_1rw_ctrl #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) dut (
        .clk(clk), .reset(reset),
        .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
        .req_addr(req_addr), .req_wdata(req_wdata),
        .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata),
        .sram_addr(sram_addr), .sram_data(sram_data),
        .sram_csb(sram_csb), .sram_web(sram_web), .sram_oeb(sram_oeb)
`ifdef SRAM_CTRL_STATS_EN
        , .wr_count(wr_count), .rd_count(rd_count)
`endif
    );

    // Behavioural 1RW SRAM: posedge-sampled, drives the bus in the cycle after a read edge.
    logic [DW-1:0] sram_mem [0:DEPTH-1];
    logic [DW-1:0] sram_q;
    logic          sram_rd_q;
    always @(posedge clk) begin
        if (!sram_csb && !sram_web) sram_mem[sram_addr] <= sram_data;
        if (!sram_csb && sram_web) sram_q <= sram_mem[sram_addr];
        sram_rd_q <= !sram_csb && sram_web;
    end
    assign sram_data = (sram_rd_q && !sram_oeb && sram_web) ? sram_q : {DW{1'bz}};

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "timeout");
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic sample();
        @(negedge clk);
    endtask

    task automatic drive(input logic v, input logic we, input logic [AW-1:0] a, input logic [DW-1:0] d);
        req_valid = v;
        req_we    = we;
        req_addr  = a;
        req_wdata = d;
    endtask

    task automatic do_write(input logic [AW-1:0] a, input logic [DW-1:0] d);
        step();
        drive(1'b1, 1'b1, a, d);
        step();
        drive(1'b0, 1'b0, '0, '0);
    endtask

    // Issues one read from an idle controller; lat = posedges from accept to rsp_valid, -1 if none.
    task automatic do_read(input logic [AW-1:0] a, output logic [DW-1:0] d, output int lat);
        step();
        drive(1'b1, 1'b0, a, '0);
        step();
        drive(1'b0, 1'b0, '0, '0);
        lat = -1;
        d   = '0;
        for (int k = 0; k < 6; k++) begin
            if (k > 0) step();
            sample();
            if (rsp_valid === 1'b1 && lat < 0) begin
                lat = k;
                d   = rsp_rdata;
            end
        end
    endtask

    task automatic test_reset();
        reset = 1'b1;
        drive(1'b0, 1'b0, '0, '0);
        step();
        step();
        sample();
        n_tests++;
        if ({sram_csb, sram_web, sram_oeb} !== 3'b111) begin
            n_fail++; $display("FAIL rst_strobes got=%b exp=111", {sram_csb, sram_web, sram_oeb});
        end
        n_tests++;
        if (rsp_valid !== 1'b0 || req_ready !== 1'b1) begin
            n_fail++; $display("FAIL rst_handshake got rsp_valid=%b req_ready=%b exp 0/1", rsp_valid, req_ready);
        end
        n_tests++;
        if (sram_addr !== '0 || rsp_rdata !== '0) begin
            n_fail++; $display("FAIL rst_regs got addr=%h rdata=%h exp 0/0", sram_addr, rsp_rdata);
        end
        n_tests++;
        if (!((sram_data === {DW{1'bz}}) || (sram_data === '0))) begin
            n_fail++; $display("FAIL rst_bus got=%h exp released", sram_data);
        end
        reset = 1'b0;
        step();
    endtask

    task automatic test_write_read();
        logic [DW-1:0] pat;
        pat = {16{8'hA5}};
        step(); drive(1'b1, 1'b1, 10'h005, pat); sample();
        n_tests++;
        if (req_ready !== 1'b1) begin n_fail++; $display("FAIL wr_ready got=%b exp=1", req_ready); end
        step(); drive(1'b0, 1'b0, '0, '0); sample();
        n_tests++;
        if ({sram_csb, sram_web, sram_oeb} !== 3'b001 || sram_addr !== 10'h005 || sram_data !== pat) begin
            n_fail++; $display("FAIL wr_cycle got strobes=%b addr=%h data=%h exp 001/005/%h",
                               {sram_csb, sram_web, sram_oeb}, sram_addr, sram_data, pat);
        end
        step(); drive(1'b1, 1'b0, 10'h005, '0); sample();
        n_tests++;
        if ({sram_csb, sram_web, sram_oeb} !== 3'b111) begin
            n_fail++; $display("FAIL wr_single got strobes=%b exp=111", {sram_csb, sram_web, sram_oeb});
        end
        step(); drive(1'b0, 1'b0, '0, '0); sample();
        n_tests++;
        if ({sram_csb, sram_web, sram_oeb} !== 3'b010 || req_ready !== 1'b0 || rsp_valid !== 1'b0) begin
            n_fail++; $display("FAIL rd_read_state got strobes=%b ready=%b rsp=%b exp 010/0/0",
                               {sram_csb, sram_web, sram_oeb}, req_ready, rsp_valid);
        end
        step(); sample();
        n_tests++;
        if (rsp_valid !== 1'b0 || req_ready !== 1'b1) begin
            n_fail++; $display("FAIL rd_wait_state got rsp=%b ready=%b exp 0/1", rsp_valid, req_ready);
        end
        step(); sample();
        n_tests++;
        if (rsp_valid !== 1'b1 || rsp_rdata !== pat) begin
            n_fail++; $display("FAIL rd_rsp got valid=%b data=%h exp 1/%h", rsp_valid, rsp_rdata, pat);
        end
        step(); sample();
        n_tests++;
        if (rsp_valid !== 1'b0 || {sram_csb, sram_web, sram_oeb} !== 3'b111) begin
            n_fail++; $display("FAIL rd_pulse got valid=%b strobes=%b exp 0/111", rsp_valid, {sram_csb, sram_web, sram_oeb});
        end
    endtask

    task automatic test_back_to_back();
        logic [AW-1:0] a;
        logic [DW-1:0] d;
        int            lat;
        for (int i = 0; i < 4; i++) begin
            a = AW'(32'h3FC + i);
            step(); drive(1'b1, 1'b1, a, DW'(a)); sample();
            n_tests++;
            if (req_ready !== 1'b1) begin n_fail++; $display("FAIL b2b_ready[%0d] got=%b exp=1", i, req_ready); end
            if (i > 0) begin
                n_tests++;
                if (sram_web !== 1'b0 || sram_csb !== 1'b0 || sram_addr !== AW'(a - 1) || sram_data !== DW'(AW'(a - 1))) begin
                    n_fail++; $display("FAIL b2b_write[%0d] got web=%b addr=%h data=%h exp 0/%h", i - 1, sram_web, sram_addr, sram_data, AW'(a - 1));
                end
            end
        end
        step(); drive(1'b0, 1'b0, '0, '0); sample();
        n_tests++;
        if (sram_web !== 1'b0 || sram_addr !== 10'h3FF || sram_data !== DW'(10'h3FF)) begin
            n_fail++; $display("FAIL b2b_write[3] got web=%b addr=%h data=%h exp 0/3ff", sram_web, sram_addr, sram_data);
        end
        step(); sample();
        n_tests++;
        if (sram_web !== 1'b1) begin n_fail++; $display("FAIL b2b_end got web=%b exp=1", sram_web); end
        for (int i = 0; i < 4; i++) begin
            a = AW'(32'h3FC + i);
            do_read(a, d, lat);
            n_tests++;
            if (lat != 2 || d !== DW'(a)) begin
                n_fail++; $display("FAIL b2b_readback[%0d] got lat=%0d data=%h exp 2/%h", i, lat, d, DW'(a));
            end
        end
    endtask

    task automatic test_read_write_read();
        step(); drive(1'b1, 1'b0, 10'h3FF, '0); sample();
        n_tests++;
        if (req_ready !== 1'b1) begin n_fail++; $display("FAIL rwr_ready0 got=%b exp=1", req_ready); end
        step(); drive(1'b1, 1'b1, 10'h3FF, DW'(16'h1234)); sample();
        n_tests++;
        if (req_ready !== 1'b0) begin n_fail++; $display("FAIL rwr_read_busy got=%b exp=0", req_ready); end
        step(); sample();
        n_tests++;
        if (req_ready !== 1'b1 || rsp_valid !== 1'b0 || $isunknown(sram_data)) begin
            n_fail++; $display("FAIL rwr_wait got ready=%b rsp=%b bus=%h exp 1/0/known", req_ready, rsp_valid, sram_data);
        end
        step(); drive(1'b1, 1'b0, 10'h3FF, '0); sample();
        n_tests++;
        if (rsp_valid !== 1'b1 || rsp_rdata !== DW'(10'h3FF)) begin
            n_fail++; $display("FAIL rwr_rsp1 got valid=%b data=%h exp 1/3ff", rsp_valid, rsp_rdata);
        end
        n_tests++;
        if (sram_web !== 1'b0 || $isunknown(sram_data) || sram_data !== DW'(16'h1234)) begin
            n_fail++; $display("FAIL rwr_write got web=%b bus=%h exp 0/1234", sram_web, sram_data);
        end
        step(); drive(1'b0, 1'b0, '0, '0); sample();
        n_tests++;
        if ({sram_csb, sram_web, sram_oeb} !== 3'b010 || rsp_valid !== 1'b0) begin
            n_fail++; $display("FAIL rwr_read2 got strobes=%b rsp=%b exp 010/0", {sram_csb, sram_web, sram_oeb}, rsp_valid);
        end
        step(); sample();
        step(); sample();
        n_tests++;
        if (rsp_valid !== 1'b1 || rsp_rdata !== DW'(16'h1234)) begin
            n_fail++; $display("FAIL rwr_rsp2 got valid=%b data=%h exp 1/1234", rsp_valid, rsp_rdata);
        end
    endtask

    task automatic test_reset_mid_read();
        logic [DW-1:0] pat, d;
        int            lat, seen;
        pat = {4{32'hC0FFEE01}};
        do_write(10'h001, pat);
        step(); drive(1'b1, 1'b0, 10'h001, '0); sample();
        step(); drive(1'b0, 1'b0, '0, '0); sample();
        step(); reset = 1'b1; sample();
        n_tests++;
        if ({sram_csb, sram_web, sram_oeb} !== 3'b010) begin
            n_fail++; $display("FAIL rstrd_wait got strobes=%b exp=010", {sram_csb, sram_web, sram_oeb});
        end
        step(); reset = 1'b0; sample();
        n_tests++;
        if ({sram_csb, sram_web, sram_oeb} !== 3'b111 || rsp_valid !== 1'b0 || req_ready !== 1'b1) begin
            n_fail++; $display("FAIL rstrd_after got strobes=%b rsp=%b ready=%b exp 111/0/1",
                               {sram_csb, sram_web, sram_oeb}, rsp_valid, req_ready);
        end
        n_tests++;
        if (!((sram_data === {DW{1'bz}}) || (sram_data === '0))) begin
            n_fail++; $display("FAIL rstrd_bus got=%h exp released", sram_data);
        end
        seen = 0;
        for (int k = 0; k < 3; k++) begin
            step(); sample();
            if (rsp_valid !== 1'b0) seen++;
        end
        n_tests++;
        if (seen != 0) begin n_fail++; $display("FAIL rstrd_dropped got %0d pulses exp 0", seen); end
        do_read(10'h001, d, lat);
        n_tests++;
        if (lat != 2 || d !== pat) begin
            n_fail++; $display("FAIL rstrd_next got lat=%0d data=%h exp 2/%h", lat, d, pat);
        end
    endtask

    task automatic test_reset_mid_write();
        logic [DW-1:0] pat, d;
        int            lat;
        pat = {8{16'h5A3C}};
        step(); drive(1'b1, 1'b1, 10'h010, pat); sample();
        step(); drive(1'b0, 1'b0, '0, '0); reset = 1'b1; sample();
        n_tests++;
        if ({sram_csb, sram_web, sram_oeb} !== 3'b001) begin
            n_fail++; $display("FAIL rstwr_write got strobes=%b exp=001", {sram_csb, sram_web, sram_oeb});
        end
        step(); reset = 1'b0; sample();
        n_tests++;
        if ({sram_csb, sram_web, sram_oeb} !== 3'b111 || req_ready !== 1'b1) begin
            n_fail++; $display("FAIL rstwr_after got strobes=%b ready=%b exp 111/1", {sram_csb, sram_web, sram_oeb}, req_ready);
        end
        do_read(10'h010, d, lat);
        n_tests++;
        if (lat != 2 || d !== pat) begin
            n_fail++; $display("FAIL rstwr_commit got lat=%0d data=%h exp 2/%h", lat, d, pat);
        end
    endtask

    // Reference: in-order memory image plus a queue of read responses due at cycle accept+3.
    task automatic test_random();
        logic [DW-1:0] ref_mem [16];
        exp_t          q[$];
        exp_t          e;
        logic          v, we, acc;
        logic [3:0]    idx;
        logic [AW-1:0] a;
        logic [DW-1:0] d, prev_wd;
        logic [AW-1:0] prev_a;
        logic          prev_wr = 1'b0, prev_rd = 1'b0, prev2_rd = 1'b0;
        logic [2:0]    exp_strb;
        for (int i = 0; i < 16; i++) begin
            d = {$urandom, $urandom, $urandom, $urandom};
            ref_mem[i] = d;
            step(); drive(1'b1, 1'b1, AW'(32'h100 + i), d);
        end
        step(); drive(1'b0, 1'b0, '0, '0);
        step();
        for (int c = 0; c < 300; c++) begin
            step();
            v   = (c < 296) && ($urandom_range(0, 3) != 0);
            we  = 1'($urandom_range(0, 1));
            idx = 4'($urandom_range(0, 15));
            a   = AW'(32'h100) + AW'(idx);
            d   = {$urandom, $urandom, $urandom, $urandom};
            drive(v, we, a, d);
            sample();
            n_tests++;
            if (req_ready !== !prev_rd) begin
                n_fail++; $display("FAIL rnd_ready c=%0d got=%b exp=%b", c, req_ready, !prev_rd);
            end
            exp_strb = prev_wr ? 3'b001 : ((prev_rd || prev2_rd) ? 3'b010 : 3'b111);
            n_tests++;
            if ({sram_csb, sram_web, sram_oeb} !== exp_strb) begin
                n_fail++; $display("FAIL rnd_strobes c=%0d got=%b exp=%b", c, {sram_csb, sram_web, sram_oeb}, exp_strb);
            end
            if (prev_wr) begin
                n_tests++;
                if (sram_addr !== prev_a || sram_data !== prev_wd) begin
                    n_fail++; $display("FAIL rnd_wbus c=%0d got addr=%h data=%h exp %h/%h", c, sram_addr, sram_data, prev_a, prev_wd);
                end
            end
            n_tests++;
            if (q.size() > 0 && q[0].due == c) begin
                e = q.pop_front();
                if (rsp_valid !== 1'b1 || rsp_rdata !== e.data) begin
                    n_fail++; $display("FAIL rnd_rsp c=%0d got valid=%b data=%h exp 1/%h", c, rsp_valid, rsp_rdata, e.data);
                end
            end else if (rsp_valid !== 1'b0) begin
                n_fail++; $display("FAIL rnd_spurious c=%0d got valid=%b exp=0", c, rsp_valid);
            end
            acc      = v && !prev_rd;
            prev2_rd = prev_rd;
            prev_rd  = acc && !we;
            prev_wr  = acc && we;
            prev_a   = a;
            prev_wd  = d;
            if (acc) begin
                if (we) begin
                    ref_mem[idx] = d;
                end else begin
                    e.data = ref_mem[idx];
                    e.due  = c + 3;
                    q.push_back(e);
                end
            end
        end
        n_tests++;
        if (q.size() != 0) begin n_fail++; $display("FAIL rnd_drain got %0d pending exp 0", q.size()); end
    endtask

`ifdef SRAM_CTRL_STATS_EN
    task automatic test_stats();
        logic [DW-1:0] d;
        int            lat;
        step(); reset = 1'b1;
        step(); reset = 1'b0; sample();
        n_tests++;
        if (wr_count !== 32'd0 || rd_count !== 32'd0) begin
            n_fail++; $display("FAIL stats_clear got wr=%0d rd=%0d exp 0/0", wr_count, rd_count);
        end
        for (int i = 0; i < 3; i++) begin
            step(); drive(1'b1, 1'b1, AW'(32'h20 + i), DW'(i + 7));
        end
        step(); drive(1'b0, 1'b0, '0, '0);
        step();
        do_read(10'h020, d, lat);
        do_read(10'h022, d, lat);
        step(); sample();
        n_tests++;
        if (wr_count !== 32'd3 || rd_count !== 32'd2) begin
            n_fail++; $display("FAIL stats_count got wr=%0d rd=%0d exp 3/2", wr_count, rd_count);
        end
        step(); reset = 1'b1;
        step(); reset = 1'b0; sample();
        n_tests++;
        if (wr_count !== 32'd0 || rd_count !== 32'd0) begin
            n_fail++; $display("FAIL stats_reset got wr=%0d rd=%0d exp 0/0", wr_count, rd_count);
        end
    endtask
`endif

    initial begin
        reset = 1'b1;
        drive(1'b0, 1'b0, '0, '0);
        test_reset();
        test_write_read();
        test_back_to_back();
        test_read_write_read();
        test_reset_mid_read();
        test_reset_mid_write();
        test_random();
`ifdef SRAM_CTRL_STATS_EN
        test_stats();
`endif
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
